// File: rtl/prog_feeder.sv
// prog_feeder: program/operand byte source feeding the processor Din bus.
// A host loads bytes into a small RAM and then starts a run. During the run one
// byte is presented at a time, and pc advances on each consume pulse.
//
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   load_we/addr/data       host write port into program RAM (ignored in RUN)
//   start, abort            run control pulses (abort has top priority)
//   consume                 processor has latched the current dout byte
//   dout, valid, pc         presented byte, its live flag, and its address
//   done, busy              run complete / run in progress
module prog_feeder #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_we,
   input  logic [AW-1:0] load_addr,
   input  logic [DW-1:0] load_data,
   input  logic          start,
   input  logic          abort,
   input  logic          consume,
   output logic [DW-1:0] dout,
   output logic          valid,
   output logic [AW-1:0] pc,
   output logic          done,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e        state_q;
   logic [AW-1:0] pc_q;
   logic [AW:0]   len_q;
   logic          valid_q;
   logic          done_q;
   logic          busy_q;

   logic [DW-1:0] mem_q [2**AW];

   logic          wr_en;
   logic [AW:0]   len_d;
   logic [AW-1:0] pc_d;
   logic          last_byte;

   always_comb begin
      wr_en     = load_we && (state_q != S_RUN);
      len_d     = {1'b0, load_addr} + {{AW{1'b0}}, 1'b1};
      pc_d      = pc_q + {{(AW-1){1'b0}}, 1'b1};
      // len is at least 1 whenever RUN is entered, so len-1 never underflows here
      last_byte = ({1'b0, pc_q} == (len_q - {{AW{1'b0}}, 1'b1}));
   end

   // Program RAM has no reset; contents survive reset and abort.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         // Length tracks the most recent accepted write, independent of abort.
         if (wr_en) begin
            len_q <= len_d;
         end
         if (abort) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  // A write in the same cycle as start wins; start is dropped.
                  if (!load_we && start && (len_q != '0)) begin
                     state_q <= S_RUN;
                     pc_q    <= '0;
                     valid_q <= 1'b1;
                     done_q  <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (consume) begin
                     if (last_byte) begin
                        state_q <= S_DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        pc_q <= pc_d;
                     end
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  pc_q    <= '0;
                  valid_q <= 1'b0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign dout  = valid_q ? mem_q[pc_q] : '0;
   assign valid = valid_q;
   assign pc    = pc_q;
   assign done  = done_q;
   assign busy  = busy_q;

endmodule

// File: doc/prog_feeder.md
Name: prog_feeder

Overview:
- Program/operand byte source sitting directly upstream of the processor's 8-bit Din input; its dout drives Din.
- A host loads a byte program into an internal RAM, then starts a run.
- During a run the block presents one byte at a time and advances its program counter on each consume pulse. The consume pulse is generated by processor-side control once the current Din byte has been latched (IR load or immediate load).

Parameters:
AW, 4, address width; program RAM depth is 2**AW bytes
DW, 8, data width; must match processor Din width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
load_we  input  1  host write strobe into program RAM
load_addr  input  AW  host write address
load_data  input  DW  host write data
start  input  1  one-cycle pulse: begin run from address 0
abort  input  1  one-cycle pulse: terminate run, return to IDLE
consume  input  1  one-cycle pulse: current dout byte taken by processor
dout  output  DW  byte presented to processor Din
valid  output  1  dout holds a live program byte
pc  output  AW  address of byte currently presented
done  output  1  run completed, all bytes consumed
busy  output  1  high in RUN state

Behaviour:
- One clock domain. Reset is asynchronous, active-high. Clock port is clk; reset port is reset.
- Reset values:
  - state=IDLE; pc=0; len=0; valid=0; done=0; busy=0; dout=0.
  - RAM contents are not reset.
- Storage:
  - 2**AW x DW RAM, written synchronously.
  - len register, width AW+1.
  - Each accepted write sets len = load_addr+1. The last write defines program length; writes need not be in address order.
- States: IDLE, RUN, DONE.
  - IDLE:
    - load_we accepted.
    - start with len!=0 -> RUN, pc=0.
    - start with len==0 is ignored; stays IDLE.
  - RUN:
    - valid=1, busy=1, dout=mem[pc] combinationally.
    - consume with pc < len-1 -> pc+1.
    - consume with pc == len-1 -> DONE, valid=0, pc held.
    - No consume -> pc and dout hold indefinitely; no timeout.
  - DONE:
    - done=1, valid=0.
    - load_we accepted.
    - start -> RUN, pc=0, done=0 (same len check as IDLE).
    - abort -> IDLE.
- dout is 0 whenever valid=0.
- Latency: a consume on cycle n changes pc and dout on cycle n+1. The processor may consume again on cycle n+1.
- load_we while in RUN is ignored: no RAM write, no len change.
- consume while not in RUN is ignored.
- Simultaneous events:
  - load_we and start in the same cycle (IDLE/DONE): the write is accepted and start is ignored.
  - abort has priority over start and consume in any state: abort -> IDLE, pc=0, valid=0, done=0.
- Full-depth boundary:
  - len max = 2**AW (16 at default), reached by writing the top address.
  - pc never wraps; the final consume at pc=2**AW-1 goes to DONE.
- Reset asserted mid-run: immediate return to reset values. RAM and len are lost only in the sense that len=0; RAM data remains.

Test Plan:
- Reset then load 3 bytes (addr0=8'h40, addr1=8'h05, addr2=8'h11), pulse start -> valid=1, pc=0, dout=8'h40.
- Pulse consume on 3 consecutive cycles:
  - dout follows 8'h05, then 8'h11.
  - After the third consume: done=1, valid=0, dout=0, pc=2.
- Start with len=0 after reset -> state stays IDLE, valid=0, busy=0.
- Load all 16 addresses, run with back-to-back consume every cycle -> 16 bytes presented in order with no repeat or wrap; done after the 16th consume; pc=15.
- Mid-run abort together with consume at pc=1 -> next cycle IDLE, pc=0, valid=0, done=0. load_we attempted during RUN leaves RAM and len unchanged (verify on rerun).
- Assert reset asynchronously mid-run (between clock edges) -> outputs go to 0 immediately. load_we+start in the same cycle in DONE -> write lands, state stays DONE.
